game_sprite_mover: RTL and testbench
====================================

Name: game_sprite_mover

Overview:
- Per-sprite motion controller that sits directly upstream of the sprite display stage.
- Generates sprite_x/sprite_y for the display and steps the sprite by a signed velocity once every N video frames.
- Consumes the display's registered sprite_within_screen flag to detect when the sprite has left the screen, then retires the sprite and reports done.

Parameters:
X_WIDTH, 10, X coordinate width in bits (matches display stage)
Y_WIDTH, 10, Y coordinate width in bits
V_WIDTH, 4, width of signed per-step velocity (two's complement)
STRIDE_WIDTH, 4, width of frames-per-step divider

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
launch  in  1  single-cycle request: load start position/velocity and begin
launch_x  in  X_WIDTH  start X (top-left)
launch_y  in  Y_WIDTH  start Y
launch_dx  in  V_WIDTH  signed X step per move
launch_dy  in  V_WIDTH  signed Y step per move
launch_stride  in  STRIDE_WIDTH  frames per move; 0 treated as 1
frame_strobe  in  1  one-cycle pulse once per video frame (vertical blank)
sprite_within_screen  in  1  registered flag from display stage, valid 1 clk after sprite_x/y change
sprite_x  out  X_WIDTH  registered sprite X to display stage
sprite_y  out  Y_WIDTH  registered sprite Y to display stage
sprite_enable  out  1  sprite visible/live; gates display rgb_en downstream
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when sprite retires (left screen or launched off-screen)

Behaviour:
- Reset (async, immediate): state=IDLE, sprite_x=0, sprite_y=0, sprite_enable=0, done=0, busy=0, stored dx/dy/stride=0, frame counter=0.
- States: IDLE, SETTLE, MOVE.
- launch has priority in every state (relaunch allowed):
  - load sprite_x/y, dx, dy, stride (0→1); clear frame counter; sprite_enable<=0; settle counter<=0; go SETTLE.
  - launch and frame_strobe in the same cycle: launch wins, strobe dropped.
- SETTLE waits exactly 2 clocks after the position register updates: 1 clk for the display to register sprite_within_screen, 1 clk for it to be sampled.
  - On the 2nd SETTLE cycle, if sprite_within_screen=1: sprite_enable<=1, go MOVE.
  - Otherwise: sprite_enable<=0, done<=1 for one cycle, go IDLE.
  - frame_strobe is ignored in SETTLE; the frame counter holds.
- MOVE: each frame_strobe increments the frame counter.
  - When counter==stride-1 on a strobe: sprite_x<=sprite_x+sext(dx), sprite_y<=sprite_y+sext(dy), counter<=0, go SETTLE.
  - sprite_enable stays 1 through that SETTLE unless the check fails.
- Arithmetic: dx/dy sign-extended to X_WIDTH/Y_WIDTH. The sum is modulo 2^width (e.g. x=1, dx=-2 → 1023). Underflow therefore appears off-screen and retires the sprite; no clamping or bouncing.
- dx=dy=0 is legal: sprite stays in MOVE indefinitely, re-checked each step.
- busy = (state != IDLE), registered.
- done is only ever a single-cycle pulse and is never asserted in the same cycle as sprite_enable=1.
- Latency:
  - Launch: 3 clks to sprite_enable=1 (load, settle1, settle2).
  - Move step: position changes the clk after the qualifying strobe; enable drop (if exiting) 2 clks after that.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then launch (100,200), dx=+3, dy=-2, stride=1; hold sprite_within_screen per display model → enable=1 at 3rd clk after launch. After 1 strobe: (103,198); after 2nd strobe: (106,196); done never pulses.
- Launch x=636, y=10, dx=+4, dy=0, stride=1 → enable=1. First strobe moves x to 640, display flag drops → done pulses once, enable=0, busy=0, state IDLE.
- Launch x=700 (off-screen) → no enable ever; done pulse on 2nd SETTLE clk; busy low next clk.
- Stride: launch (50,50), dx=+1, stride=3, 7 strobes → x=51 after strobe 3, x=52 after strobe 6, unchanged after strobe 7.
  - Repeat with stride=0 → moves every strobe.
- Wrap: launch x=1, dx=-2 → after step x=1023 → done, enable=0. Also launch y=2, dy=-3 → y=1023 → done.
- Priority/reset:
  - launch coincident with frame_strobe in MOVE → new position loaded, no step applied, enable=0 then 1 after settle.
  - reset asserted mid-SETTLE → all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/game_sprite_mover.sv
// Per-sprite motion controller: steps a sprite by a signed velocity every N frames
// and retires it once the display stage reports it has left the screen.
module game_sprite_mover #(
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10,
  parameter int V_WIDTH      = 4,
  parameter int STRIDE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    launch,
  input  logic [X_WIDTH-1:0]      launch_x,
  input  logic [Y_WIDTH-1:0]      launch_y,
  input  logic [V_WIDTH-1:0]      launch_dx,
  input  logic [V_WIDTH-1:0]      launch_dy,
  input  logic [STRIDE_WIDTH-1:0] launch_stride,
  input  logic                    frame_strobe,
  input  logic                    sprite_within_screen,
  output logic [X_WIDTH-1:0]      sprite_x,
  output logic [Y_WIDTH-1:0]      sprite_y,
  output logic                    sprite_enable,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] MOVE   = 2'd2;

  localparam logic [STRIDE_WIDTH-1:0] STRIDE_ONE = STRIDE_WIDTH'(1);

  logic [1:0]              state;
  logic [V_WIDTH-1:0]      dx_q;
  logic [V_WIDTH-1:0]      dy_q;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [STRIDE_WIDTH-1:0] frame_cnt;
  logic                    settle_cnt;
  logic [X_WIDTH-1:0]      dx_ext;
  logic [Y_WIDTH-1:0]      dy_ext;

  // Sign-extend the velocity; the add then wraps modulo 2^width so underflow lands off-screen.
  assign dx_ext = {{(X_WIDTH - V_WIDTH){dx_q[V_WIDTH-1]}}, dx_q};
  assign dy_ext = {{(Y_WIDTH - V_WIDTH){dy_q[V_WIDTH-1]}}, dy_q};

  // NOTE: state uses non-blocking assignments only, and every register (no memories here)
  // is cleared by the async reset so outputs drop immediately when reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sprite_x      <= '0;
      sprite_y      <= '0;
      sprite_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
      stride_q      <= '0;
      frame_cnt     <= '0;
      settle_cnt    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        sprite_x      <= launch_x;
        sprite_y      <= launch_y;
        dx_q          <= launch_dx;
        dy_q          <= launch_dy;
        stride_q      <= (launch_stride == '0) ? STRIDE_ONE : launch_stride;
        frame_cnt     <= '0;
        settle_cnt    <= 1'b0;
        sprite_enable <= 1'b0;
        state         <= SETTLE;
        busy          <= 1'b1;
      end else begin
        case (state)
          SETTLE: begin
            // First cycle lets the display register its flag; second cycle samples it.
            if (!settle_cnt) begin
              settle_cnt <= 1'b1;
            end else if (sprite_within_screen) begin
              sprite_enable <= 1'b1;
              state         <= MOVE;
            end else begin
              sprite_enable <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
              busy          <= 1'b0;
            end
          end
          MOVE: begin
            if (frame_strobe) begin
              if (frame_cnt == stride_q - STRIDE_ONE) begin
                sprite_x   <= sprite_x + dx_ext;
                sprite_y   <= sprite_y + dy_ext;
                frame_cnt  <= '0;
                settle_cnt <= 1'b0;
                state      <= SETTLE;
              end else begin
                frame_cnt <= frame_cnt + STRIDE_ONE;
              end
            end
          end
          IDLE: begin
          end
          default: begin
            sprite_enable <= 1'b0;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sprite_mover.sv
// Directed bench for game_sprite_mover with a 640x480 registered display-flag model.
module tb_game_sprite_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       launch = 1'b0;
  logic [9:0] launch_x = '0;
  logic [9:0] launch_y = '0;
  logic [3:0] launch_dx = '0;
  logic [3:0] launch_dy = '0;
  logic [3:0] launch_stride = '0;
  logic       frame_strobe = 1'b0;
  logic       sprite_within_screen;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       sprite_enable;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int done_mark;

  game_sprite_mover dut (
    .clk                  (clk),
    .reset                (reset),
    .launch               (launch),
    .launch_x             (launch_x),
    .launch_y             (launch_y),
    .launch_dx            (launch_dx),
    .launch_dy            (launch_dy),
    .launch_stride        (launch_stride),
    .frame_strobe         (frame_strobe),
    .sprite_within_screen (sprite_within_screen),
    .sprite_x             (sprite_x),
    .sprite_y             (sprite_y),
    .sprite_enable        (sprite_enable),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  // Display stage model: registered on-screen flag for a 640x480 screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sprite_within_screen <= 1'b0;
    else       sprite_within_screen <= (sprite_x < 10'd640) && (sprite_y < 10'd480);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && sprite_enable) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_launch(input logic [9:0] x, input logic [9:0] y,
                           input logic [3:0] dx, input logic [3:0] dy,
                           input logic [3:0] stride, input logic with_strobe);
    launch        = 1'b1;
    launch_x      = x;
    launch_y      = y;
    launch_dx     = dx;
    launch_dy     = dy;
    launch_stride = stride;
    frame_strobe  = with_strobe;
    tick();
    launch        = 1'b0;
    frame_strobe  = 1'b0;
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_x", 32'(sprite_x), 0);
    check("reset_en", 32'(sprite_enable), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic move: (100,200) dx=+3 dy=-2 stride=1
    do_launch(10'd100, 10'd200, 4'd3, 4'hE, 4'd1, 1'b0);
    check("t1_load_x", 32'(sprite_x), 100);
    check("t1_load_en", 32'(sprite_enable), 0);
    tick();
    check("t1_settle1_en", 32'(sprite_enable), 0);
    check("t1_settle1_busy", 32'(busy), 1);
    tick();
    check("t1_en", 32'(sprite_enable), 1);
    strobe();
    check("t1_s1_x", 32'(sprite_x), 103);
    check("t1_s1_y", 32'(sprite_y), 198);
    tick(); tick();
    check("t1_s1_en", 32'(sprite_enable), 1);
    strobe();
    check("t1_s2_x", 32'(sprite_x), 106);
    check("t1_s2_y", 32'(sprite_y), 196);
    tick(); tick();
    check("t1_s2_en", 32'(sprite_enable), 1);
    check("t1_no_done", 32'(done_cnt), 0);

    // Exit on the right edge
    done_mark = done_cnt;
    do_launch(10'd636, 10'd10, 4'd4, 4'd0, 4'd1, 1'b0);
    tick(); tick();
    check("t2_en", 32'(sprite_enable), 1);
    strobe();
    check("t2_x", 32'(sprite_x), 640);
    tick();
    check("t2_settle1_done", 32'(done), 0);
    tick();
    check("t2_done", 32'(done), 1);
    check("t2_en_off", 32'(sprite_enable), 0);
    tick();
    check("t2_done_clr", 32'(done), 0);
    check("t2_busy", 32'(busy), 0);
    check("t2_done_once", 32'(done_cnt - done_mark), 1);

    // Launched off-screen
    done_mark = done_cnt;
    do_launch(10'd700, 10'd10, 4'd1, 4'd0, 4'd1, 1'b0);
    check("t3_load_en", 32'(sprite_enable), 0);
    tick();
    check("t3_settle1_done", 32'(done), 0);
    tick();
    check("t3_done", 32'(done), 1);
    check("t3_en", 32'(sprite_enable), 0);
    tick();
    check("t3_busy", 32'(busy), 0);
    check("t3_done_once", 32'(done_cnt - done_mark), 1);

    // Stride 3: seven strobes, expected x = 50 + s/3
    do_launch(10'd50, 10'd50, 4'd1, 4'd0, 4'd3, 1'b0);
    tick(); tick();
    for (int s = 1; s <= 7; s++) begin
      strobe();
      check($sformatf("t4_stride3_x%0d", s), 32'(sprite_x), 32'(50 + s / 3));
      tick(); tick();
    end
    check("t4_en", 32'(sprite_enable), 1);

    // Stride 0 behaves as 1
    do_launch(10'd50, 10'd50, 4'd1, 4'd0, 4'd0, 1'b0);
    tick(); tick();
    for (int s = 1; s <= 2; s++) begin
      strobe();
      check($sformatf("t4_stride0_x%0d", s), 32'(sprite_x), 32'(50 + s));
      tick(); tick();
    end

    // X wrap-around
    done_mark = done_cnt;
    do_launch(10'd1, 10'd100, 4'hE, 4'd0, 4'd1, 1'b0);
    tick(); tick();
    check("t5x_en", 32'(sprite_enable), 1);
    strobe();
    check("t5x_wrap", 32'(sprite_x), 1023);
    tick(); tick();
    check("t5x_done", 32'(done), 1);
    check("t5x_en_off", 32'(sprite_enable), 0);

    // Y wrap-around
    do_launch(10'd100, 10'd2, 4'd0, 4'hD, 4'd1, 1'b0);
    tick(); tick();
    check("t5y_en", 32'(sprite_enable), 1);
    strobe();
    check("t5y_wrap", 32'(sprite_y), 1023);
    tick(); tick();
    check("t5y_done", 32'(done), 1);
    check("t5y_en_off", 32'(sprite_enable), 0);
    tick();
    check("t5_done_cnt", 32'(done_cnt - done_mark), 2);

    // Launch coincident with strobe in MOVE
    do_launch(10'd10, 10'd10, 4'd1, 4'd1, 4'd1, 1'b0);
    tick(); tick();
    check("t6_first_en", 32'(sprite_enable), 1);
    do_launch(10'd300, 10'd300, 4'd5, 4'd5, 4'd1, 1'b1);
    check("t6_x", 32'(sprite_x), 300);
    check("t6_y", 32'(sprite_y), 300);
    check("t6_en_off", 32'(sprite_enable), 0);
    tick(); tick();
    check("t6_en_on", 32'(sprite_enable), 1);
    check("t6_no_step", 32'(sprite_x), 300);

    // Reset mid-SETTLE
    do_launch(10'd20, 10'd20, 4'd1, 4'd1, 4'd1, 1'b0);
    tick();
    done_mark = done_cnt;
    reset = 1'b1;
    #1;
    check("t7_x", 32'(sprite_x), 0);
    check("t7_y", 32'(sprite_y), 0);
    check("t7_en", 32'(sprite_enable), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("t7_no_done", 32'(done_cnt - done_mark), 0);
    check("t7_busy_after", 32'(busy), 0);

    check("done_enable_overlap", 32'(overlap_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
